iq_demod_ctrl: RTL

Sequencing and pairing controller for the IQ demodulation chain. Sits between the ADC sample strobe, the two `filter_20` instances (I and Q), and the downstream CORDIC. It gates the filters' input strobe, discards filter warm-up outputs, and re-aligns the independently produced I and Q filter outputs through small skew FIFOs. It emits one `demod_iq_valid` pulse per matched I/Q pair and detects overflow or excessive skew.

---
 rtl/iq_demod_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/iq_demod_ctrl.sv
// iq_demod_ctrl: gates I/Q filter strobes, drops warm-up pairs, re-pairs I/Q through skew FIFOs.
// Ports: clk/resetn (async active-low); en, ADC_rdy -> filter_en; I_filt/valid_out_I, Q_filt/valid_out_Q
// from the filters; I_BB/Q_BB/demod_iq_valid to the CORDIC; state, err_ovf, err_skew status.
// IQ_DEMOD_CTRL_STATS_EN adds pair_cnt, a saturating count of emitted pairs.
module iq_demod_ctrl #(
  parameter int DATA_W     = 5,
  parameter int WARMUP     = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SKEW   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en,
  input  logic                     ADC_rdy,
  output logic                     filter_en,
  input  logic signed [DATA_W-1:0] I_filt,
  input  logic                     valid_out_I,
  input  logic signed [DATA_W-1:0] Q_filt,
  input  logic                     valid_out_Q,
  output logic signed [DATA_W-1:0] I_BB,
  output logic signed [DATA_W-1:0] Q_BB,
  output logic                     demod_iq_valid,
  output logic [1:0]               state,
  output logic                     err_ovf,
`ifdef IQ_DEMOD_CTRL_STATS_EN
  output logic                     err_skew,
  output logic [15:0]              pair_cnt
`else
  output logic                     err_skew
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0] WLAST = 8'(WARMUP - 1);
  localparam logic [7:0] SLAST = 8'(MAX_SKEW - 1);
  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_ERR} state_t;
  state_t st;
  logic signed [DATA_W-1:0] fifo_i [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rp, wp_i, wp_q;
  logic [CW-1:0] cnt_i, cnt_q;
  logic [7:0] wcnt, skew;
  logic active, empty_i, empty_q, full_i, full_q, pop, push_i, push_q, ovf, one_ne, skew_hit, emit;
  always_comb begin
    active   = st == S_WARM || st == S_RUN;
    empty_i  = cnt_i == '0;
    empty_q  = cnt_q == '0;
    full_i   = cnt_i == FULL;
    full_q   = cnt_q == FULL;
    pop      = active && !empty_i && !empty_q;
    push_i   = active && valid_out_I && (!full_i || pop);
    push_q   = active && valid_out_Q && (!full_q || pop);
    ovf      = active && !pop && ((valid_out_I && full_i) || (valid_out_Q && full_q));
    one_ne   = empty_i ^ empty_q;
    skew_hit = active && one_ne && skew == SLAST;
    emit     = en && pop && st == S_RUN;
    filter_en = ADC_rdy && active;
  end
  assign state = st;
  always_ff @(posedge clk) begin
    if (push_i) fifo_i[wp_i] <= I_filt;
    if (push_q) fifo_q[wp_q] <= Q_filt;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st <= S_IDLE;
      rp <= '0;
      wp_i <= '0;
      wp_q <= '0;
      cnt_i <= '0;
      cnt_q <= '0;
      wcnt <= '0;
      skew <= '0;
      I_BB <= '0;
      Q_BB <= '0;
      demod_iq_valid <= 1'b0;
      err_ovf <= 1'b0;
      err_skew <= 1'b0;
    end else begin
      demod_iq_valid <= emit;
      if (emit) begin
        I_BB <= fifo_i[rp];
        Q_BB <= fifo_q[rp];
      end
      if (!en || st == S_IDLE) begin
        st <= !en ? S_IDLE : (WARMUP == 0 ? S_RUN : S_WARM);
        rp <= '0;
        wp_i <= '0;
        wp_q <= '0;
        cnt_i <= '0;
        cnt_q <= '0;
        wcnt <= '0;
        skew <= '0;
        if (en) begin
          err_ovf <= 1'b0;
          err_skew <= 1'b0;
        end
      end else if (active) begin
        rp <= rp + AW'(pop);
        wp_i <= wp_i + AW'(push_i);
        wp_q <= wp_q + AW'(push_q);
        cnt_i <= cnt_i + CW'(push_i) - CW'(pop);
        cnt_q <= cnt_q + CW'(push_q) - CW'(pop);
        skew <= one_ne ? skew + 8'd1 : 8'd0;
        err_ovf <= err_ovf | ovf;
        err_skew <= err_skew | skew_hit;
        if (ovf || skew_hit) st <= S_ERR;
        else if (pop && st == S_WARM) begin
          wcnt <= wcnt + 8'd1;
          if (wcnt == WLAST) st <= S_RUN;
        end
      end
    end
  end
`ifdef IQ_DEMOD_CTRL_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pair_cnt <= '0;
    else if (st == S_IDLE && en) pair_cnt <= '0;
    else if (emit) pair_cnt <= pair_cnt + {15'd0, pair_cnt != 16'hFFFF};
  end
`endif
endmodule
